// File: rtl/max_pool_2x2.sv
// 2x2 max-pool (stride 2) over a sliding 2x2 window stream.
// Two-stage pipeline with optional ReLU and row/frame completion pulses.
module max_pool_2x2 #(
  parameter int INTEGER_BITS     = 9,
  parameter int FIXED_POINT_BITS = 4,
  parameter int WIN_COLS         = 512,
  parameter int WIN_ROWS         = 510,
  parameter int RELU_EN          = 1,
  parameter int DATA_W           = INTEGER_BITS + FIXED_POINT_BITS
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4*DATA_W-1:0]   i_window_data,
  input  logic                  i_window_valid,
  output logic [DATA_W-1:0]     o_pool_data,
  output logic                  o_pool_valid,
  output logic                  o_row_done,
  output logic                  o_frame_done,
  output logic                  o_busy
);

  localparam int CW = (WIN_COLS > 2) ? $clog2(WIN_COLS) : 1;
  localparam int RW = (WIN_ROWS > 2) ? $clog2(WIN_ROWS) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(WIN_COLS - 1);
  localparam logic [CW-1:0] COL_TAG  = CW'(WIN_COLS - 2);
  localparam logic [RW-1:0] ROW_LAST = RW'(WIN_ROWS - 1);
  localparam logic [RW-1:0] ROW_TAG  = RW'(((WIN_ROWS - 1) / 2) * 2);

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;

  logic signed [DATA_W-1:0] lane0;
  logic signed [DATA_W-1:0] lane1;
  logic signed [DATA_W-1:0] lane2;
  logic signed [DATA_W-1:0] lane3;

  logic col_wrap;
  logic row_wrap;
  logic keep;
  logic tag_lc;
  logic tag_lf;

  logic                     s1_v;
  logic                     s1_lc;
  logic                     s1_lf;
  logic signed [DATA_W-1:0] s1_m01;
  logic signed [DATA_W-1:0] s1_m23;

  logic                     s2_v;
  logic                     s2_lc;
  logic                     s2_lf;
  logic [DATA_W-1:0]        s2_r;

  logic signed [DATA_W-1:0] r_max;
  logic [DATA_W-1:0]        r_out;

  assign lane0 = i_window_data[0*DATA_W +: DATA_W];
  assign lane1 = i_window_data[1*DATA_W +: DATA_W];
  assign lane2 = i_window_data[2*DATA_W +: DATA_W];
  assign lane3 = i_window_data[3*DATA_W +: DATA_W];

  // Decimation and tags use the counter values before this cycle's update
  assign col_wrap = (col_cnt == COL_LAST);
  assign row_wrap = (row_cnt == ROW_LAST);
  assign keep     = i_window_valid & ~col_cnt[0] & ~row_cnt[0];
  assign tag_lc   = (col_cnt == COL_TAG);
  assign tag_lf   = tag_lc & (row_cnt == ROW_TAG);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (i_window_valid) begin
      col_cnt <= col_wrap ? '0 : col_cnt + 1'b1;
      if (col_wrap) begin
        row_cnt <= row_wrap ? '0 : row_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_v   <= 1'b0;
      s1_lc  <= 1'b0;
      s1_lf  <= 1'b0;
      s1_m01 <= '0;
      s1_m23 <= '0;
    end else begin
      s1_v <= keep;
      if (keep) begin
        s1_lc  <= tag_lc;
        s1_lf  <= tag_lf;
        s1_m01 <= smax(lane0, lane1);
        s1_m23 <= smax(lane2, lane3);
      end
    end
  end

  always_comb begin
    r_max = smax(s1_m01, s1_m23);
    r_out = r_max;
    if ((RELU_EN != 0) && r_max[DATA_W-1]) begin
      r_out = '0;
    end
  end

  // Output data only moves on a valid result, so it holds between pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_v  <= 1'b0;
      s2_lc <= 1'b0;
      s2_lf <= 1'b0;
      s2_r  <= '0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_lc <= s1_lc;
        s2_lf <= s1_lf;
        s2_r  <= r_out;
      end
    end
  end

  assign o_pool_data  = s2_r;
  assign o_pool_valid = s2_v;
  assign o_row_done   = s2_v & s2_lc;
  assign o_frame_done = s2_v & s2_lf;
  assign o_busy       = (|col_cnt) | (|row_cnt) | s1_v | s2_v;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Bench for max_pool_2x2: directed window table, full-row decimation,
// small back-to-back frames against a max-pool model, mid-row reset.
module tb_max_pool_2x2;

  localparam int DW = 13;
  localparam int BC = 8;
  localparam int BR = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [4*DW-1:0] wd = '0;
  logic          va = 1'b0;
  logic          vb = 1'b0;

  logic [DW-1:0] a_data;
  logic          a_valid;
  logic          a_row;
  logic          a_frame;
  logic          a_busy;
  logic [DW-1:0] b_data;
  logic          b_valid;
  logic          b_row;
  logic          b_frame;
  logic          b_busy;

  max_pool_2x2 dut_a (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_window_data  (wd),
    .i_window_valid (va),
    .o_pool_data    (a_data),
    .o_pool_valid   (a_valid),
    .o_row_done     (a_row),
    .o_frame_done   (a_frame),
    .o_busy         (a_busy)
  );

  max_pool_2x2 #(
    .WIN_COLS (BC),
    .WIN_ROWS (BR),
    .RELU_EN  (0)
  ) dut_b (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_window_data  (wd),
    .i_window_valid (vb),
    .o_pool_data    (b_data),
    .o_pool_valid   (b_valid),
    .o_row_done     (b_row),
    .o_frame_done   (b_frame),
    .o_busy         (b_busy)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4*DW-1:0] pk(input int l0, input int l1,
                                         input int l2, input int l3);
    return {DW'(l3), DW'(l2), DW'(l1), DW'(l0)};
  endfunction

  function automatic int model(input logic [4*DW-1:0] w, input bit relu);
    int m;
    int v;
    m = $signed(w[DW-1:0]);
    for (int k = 1; k < 4; k++) begin
      v = $signed(w[k*DW +: DW]);
      if (v > m) m = v;
    end
    if (relu && m < 0) m = 0;
    return m;
  endfunction

  function automatic int rnd_lane();
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  // dut_a monitor: row test drives lane2 = column, so pulse n carries 2n
  bit mon_a = 1'b0;
  int a_cnt = 0;
  int a_rd = 0;
  int a_rd_at = 0;
  int a_err = 0;

  always @(negedge clk) begin
    if (mon_a && a_valid) begin
      if (int'($signed(a_data)) != 2 * a_cnt) a_err <= a_err + 1;
      a_cnt <= a_cnt + 1;
      if (a_row) begin
        a_rd    <= a_rd + 1;
        a_rd_at <= a_cnt + 1;
      end
    end
  end

  // dut_b monitor: scoreboard against queued model results
  bit mon_b = 1'b0;
  int exp_q[$];
  int b_idx = 0;
  int b_rd = 0;
  int b_fd = 0;
  int b_err = 0;
  localparam int PPR = BC / 2;
  localparam int PPF = PPR * ((BR + 1) / 2);

  always @(negedge clk) begin
    if (mon_b && b_valid) begin
      if (exp_q.size() == 0) begin
        b_err <= b_err + 1;
      end else if (int'($signed(b_data)) != exp_q.pop_front()) begin
        b_err <= b_err + 1;
      end
      if (b_frame != ((b_idx % PPF) == PPF - 1)) b_err <= b_err + 1;
      if (b_row != ((b_idx % PPR) == PPR - 1)) b_err <= b_err + 1;
      b_idx <= b_idx + 1;
      b_rd  <= b_rd + int'(b_row);
      b_fd  <= b_fd + int'(b_frame);
    end
  end

  typedef struct {
    int l[4];
    int er;
    int en;
  } vec_t;

  vec_t tv[6];
  logic [4*DW-1:0] fw[BC*BR];
  logic [4*DW-1:0] x;

  initial begin
    tv[0] = '{'{-56, 36, 112, -1}, 112, 112};
    tv[1] = '{'{-16, -32, -8, -64}, 0, -8};
    tv[2] = '{'{5, -3, 7, 7}, 7, 7};
    tv[3] = '{'{-4096, 4095, 0, 0}, 4095, 4095};
    tv[4] = '{'{-4096, -4096, -4096, -4096}, 0, -4096};
    tv[5] = '{'{0, 0, -2, 1}, 1, 1};

    for (int i = 0; i < 6; i++) begin
      rst = 1'b1;
      va = 1'b0;
      vb = 1'b0;
      step();
      chk("rst_a_valid", int'(a_valid), 0);
      chk("rst_a_data", int'(a_data), 0);
      chk("rst_a_busy", int'(a_busy), 0);
      chk("rst_b_valid", int'(b_valid), 0);
      rst = 1'b0;
      wd = pk(tv[i].l[0], tv[i].l[1], tv[i].l[2], tv[i].l[3]);
      va = 1'b1;
      vb = 1'b1;
      step();
      chk("lat1_valid", int'(a_valid), 0);
      chk("lat1_busy", int'(a_busy), 1);
      va = 1'b0;
      vb = 1'b0;
      step();
      chk("vec_a_valid", int'(a_valid), 1);
      chk("vec_a_data", int'($signed(a_data)), tv[i].er);
      chk("vec_a_row", int'(a_row), 0);
      chk("vec_b_valid", int'(b_valid), 1);
      chk("vec_b_data", int'($signed(b_data)), tv[i].en);
      wd = pk(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
      step();
      chk("pulse_a_valid", int'(a_valid), 0);
      chk("hold_a_data", int'($signed(a_data)), tv[i].er);
      chk("hold_b_data", int'($signed(b_data)), tv[i].en);
    end

    // full window row at default geometry, then an odd row
    rst = 1'b1;
    step();
    rst = 1'b0;
    mon_a = 1'b1;
    for (int c = 0; c < 512; c++) begin
      wd = pk(0, 0, c, 0);
      va = 1'b1;
      step();
    end
    va = 1'b0;
    repeat (3) step();
    chk("row0_pulses", a_cnt, 256);
    chk("row0_rowdone", a_rd, 1);
    chk("row0_rowdone_at", a_rd_at, 256);
    chk("row0_data", a_err, 0);
    chk("row0_busy", int'(a_busy), 1);
    for (int c = 0; c < 512; c++) begin
      wd = pk(c, c, c, c);
      va = 1'b1;
      step();
    end
    va = 1'b0;
    repeat (3) step();
    chk("row1_pulses", a_cnt, 256);
    chk("row1_rowdone", a_rd, 1);

    // two small frames: first with idle gaps, second gapless right after
    for (int k = 0; k < BC * BR; k++) begin
      fw[k] = pk(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    mon_b = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < BR; r++) begin
        for (int c = 0; c < BC; c++) begin
          if (f == 0) begin
            vb = 1'b0;
            repeat ($urandom_range(0, 3)) step();
          end
          wd = fw[r*BC + c];
          vb = 1'b1;
          if ((r % 2 == 0) && (c % 2 == 0)) exp_q.push_back(model(wd, 1'b0));
          step();
        end
      end
    end
    vb = 1'b0;
    chk("busy_n1", int'(b_busy), 1);
    step();
    chk("busy_n2", int'(b_busy), 0);
    repeat (3) step();
    chk("frm_left", exp_q.size(), 0);
    chk("frm_count", b_idx, 2 * PPF);
    chk("frm_rowdone", b_rd, 2 * (BR + 1) / 2);
    chk("frm_framedone", b_fd, 2);
    chk("frm_err", b_err, 0);

    // reset one cycle after a kept window mid-row
    x = pk(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
    wd = x;
    exp_q.push_back(model(x, 1'b0));
    vb = 1'b1;
    step();
    wd = pk(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
    step();
    wd = pk(4000, 4001, 4002, 4003);
    step();
    vb = 1'b0;
    rst = 1'b1;
    step();
    chk("mrst_valid", int'(b_valid), 0);
    chk("mrst_data", int'(b_data), 0);
    chk("mrst_row", int'(b_row), 0);
    chk("mrst_frame", int'(b_frame), 0);
    chk("mrst_busy", int'(b_busy), 0);
    rst = 1'b0;
    x = pk(-100, -7, -300, -9);
    wd = x;
    exp_q.push_back(model(x, 1'b0));
    vb = 1'b1;
    step();
    vb = 1'b0;
    step();
    chk("post_valid", int'(b_valid), 1);
    chk("post_data", int'($signed(b_data)), -7);
    repeat (2) step();
    chk("post_count", b_idx, 2 * PPF + 2);
    chk("post_left", exp_q.size(), 0);
    chk("post_err", b_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
